sign_extend: RTL and testbench

- Registered immediate extender for the MIPS datapath: widens a 16-bit instruction immediate to a 32-bit operand.
- Default mode is two's-complement sign extension. Selectable modes also cover zero extension and branch-offset scaling.
- Sits between instruction decode and the ALU/branch-target operand muxes; one clock of latency.

---
 rtl/sign_extend_pkg.sv | 14 +
 rtl/sign_extend_core.sv | 34 +++
 rtl/sign_extend.sv | 36 +++
 tb/tb_sign_extend.sv | 129 ++++++++++++
 4 files changed

// File: rtl/sign_extend_pkg.sv
// sign_extend_pkg: shared mode encoding and default widths for the immediate extender
package sign_extend_pkg;

    localparam int IMM_W  = 16;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        MODE_SEXT = 2'b00,
        MODE_ZEXT = 2'b01,
        MODE_LUI  = 2'b10,
        MODE_BOFF = 2'b11
    } mode_e;

endpackage

// File: rtl/sign_extend_core.sv
// sign_extend_core: combinational immediate widening (SEXT/ZEXT/LUI/BOFF); LUI needs SIGN_EXTEND_LUI_EN
module sign_extend_core
    import sign_extend_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = WORD_W
) (
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] ext
);

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] boff;
    logic [OUT_W-1:0] lui;

    assign sext = {{(OUT_W-IN_W){in[IN_W-1]}}, in};
    assign zext = {{(OUT_W-IN_W){1'b0}}, in};
    assign boff = {sext[OUT_W-3:0], 2'b00};
`ifdef SIGN_EXTEND_LUI_EN
    assign lui  = {in, {(OUT_W-IN_W){1'b0}}};
`else
    assign lui  = sext;
`endif

    // select the widened value for the requested mode
    always_comb begin
        ext = mode == MODE_ZEXT ? zext :
              mode == MODE_BOFF ? boff :
              mode == MODE_LUI  ? lui  : sext;
    end

endmodule

// File: rtl/sign_extend.sv
// sign_extend: registered 16->32 immediate extender, one cycle latency; LUI mode via SIGN_EXTEND_LUI_EN
module sign_extend
    import sign_extend_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    output logic             out_valid
);

    logic [OUT_W-1:0] ext;

    sign_extend_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
        .mode (mode),
        .in   (in),
        .ext  (ext)
    );

    // capture on enable, hold otherwise; reset overrides any capture that edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= en;
            if (en) out <= ext;
        end
    end

endmodule

// File: tb/tb_sign_extend.sv
// tb_sign_extend: scoreboard bench for sign_extend; expectations follow SIGN_EXTEND_LUI_EN when defined
module tb_sign_extend;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic [15:0] in;
    logic [31:0] out;
    logic        out_valid;

    logic [31:0] exp_q[$];
    int          tests = 0;
    int          fails = 0;

    sign_extend dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .in        (in),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [15:0] v, input logic [1:0] m, input logic [31:0] exp);
        @(posedge clk);
        #1;
        in   = v;
        mode = m;
        en   = 1'b1;
        exp_q.push_back(exp);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    // monitor: every valid output must match the oldest expected value
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got %h expected no output", out);
            end else begin
                chk("scoreboard", out, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 2'b00;
        in    = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_out", out, 32'h0);
        chk("reset_valid", {31'b0, out_valid}, 32'h0);

        issue(16'ha43d, 2'b00, 32'hffffa43d);
        issue(16'h7a0b, 2'b00, 32'h00007a0b);
        issue(16'ha43d, 2'b01, 32'h0000a43d);
        issue(16'h8000, 2'b00, 32'hffff8000);
        issue(16'h8000, 2'b01, 32'h00008000);
        issue(16'h7fff, 2'b00, 32'h00007fff);
        issue(16'hfffe, 2'b11, 32'hfffffff8);
        issue(16'h0003, 2'b11, 32'h0000000c);
        issue(16'hffff, 2'b11, 32'hfffffffc);
        issue(16'h0000, 2'b00, 32'h0);
        issue(16'h0000, 2'b01, 32'h0);
        issue(16'h0000, 2'b10, 32'h0);
        issue(16'h0000, 2'b11, 32'h0);
`ifdef SIGN_EXTEND_LUI_EN
        issue(16'h1234, 2'b10, 32'h12340000);
        issue(16'h8001, 2'b10, 32'h80010000);
`else
        issue(16'h1234, 2'b10, 32'h00001234);
        issue(16'h8001, 2'b10, 32'hffff8001);
`endif
        idle();
        idle();

        issue(16'ha43d, 2'b00, 32'hffffa43d);
        @(posedge clk);
        #1;
        en = 1'b0;
        in = 16'h1111;
        @(posedge clk);
        @(negedge clk);
        chk("hold_out", out, 32'hffffa43d);
        chk("hold_valid", {31'b0, out_valid}, 32'h0);

        #1;
        rst_n = 1'b0;
        en    = 1'b1;
        in    = 16'h7a0b;
        mode  = 2'b00;
        @(posedge clk);
        @(negedge clk);
        chk("rst_prio_out", out, 32'h0);
        chk("rst_prio_valid", {31'b0, out_valid}, 32'h0);
        rst_n = 1'b1;
        en    = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
